// File: rtl/alu_entry_pkg.sv
// Shared definitions for the ALU operand entry block: FSM states, stage
// width and the default debounce length.
package alu_entry_pkg;

  localparam int STAGE_W                 = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [STAGE_W-1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    READY    = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, run-length debouncer and
// a registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
  import alu_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differ;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_next;

  // Acceptance needs DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    w_differ   = (r_sync2 != r_level);
    w_accept   = 1'b0;
    w_cnt_next = CNT_ZERO;
    if (!w_differ) begin
      w_cnt_next = CNT_ZERO;
    end else if (r_cnt == CNT_LAST) begin
      w_accept   = 1'b1;
      w_cnt_next = CNT_ZERO;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= CNT_ZERO;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_level <= r_sync2;
      end else begin
        r_level <= r_level;
      end
      r_press <= w_accept & r_sync2;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand entry front-end for a switch-driven ALU: collects A, B and the op
// code through debounced enter/clear buttons and flags when all are present.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         sw,
  input  logic               btn_enter,
  input  logic               btn_clear,
  output logic [3:0]         A,
  output logic [3:0]         B,
  output logic [2:0]         op,
  output logic               valid,
  output logic [STAGE_W-1:0] stage,
  output logic               ack
);

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic       r_valid;
  logic       r_ack;

  state_t     w_state_next;
  logic [3:0] w_a_next;
  logic [3:0] w_b_next;
  logic [2:0] w_op_next;
  logic       w_ack_next;
  logic       w_enter_press;
  logic       w_clear_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_enter),
    .press(w_enter_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_clear),
    .press(w_clear_press)
  );

  // Next state and capture values; a clear press overrides a coincident enter.
  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_op_next    = r_op;
    w_ack_next   = 1'b0;
    if (w_clear_press) begin
      w_state_next = ENTER_A;
      w_a_next     = 4'd0;
      w_b_next     = 4'd0;
      w_op_next    = 3'd0;
      w_ack_next   = 1'b1;
    end else if (w_enter_press) begin
      w_ack_next = 1'b1;
      case (r_state)
        ENTER_A: begin
          w_a_next     = sw;
          w_state_next = ENTER_B;
        end
        ENTER_B: begin
          w_b_next     = sw;
          w_state_next = ENTER_OP;
        end
        ENTER_OP: begin
          w_op_next    = sw[2:0];
          w_state_next = READY;
        end
        READY: begin
          w_a_next     = sw;
          w_state_next = ENTER_B;
        end
        default: begin
          w_state_next = ENTER_A;
        end
      endcase
    end else begin
      w_ack_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ENTER_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand registers plus valid/ack, all updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_op    <= 3'd0;
      r_valid <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_op    <= w_op_next;
      r_valid <= (w_state_next == READY);
      r_ack   <= w_ack_next;
    end
  end

  assign A     = r_a;
  assign B     = r_b;
  assign op    = r_op;
  assign valid = r_valid;
  assign stage = r_state;
  assign ack   = r_ack;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Randomized self-checking bench for alu_operand_entry against a
// window-based behavioural model, plus directed scenarios with literal results.
module tb_alu_operand_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] op;
  logic       valid;
  logic [1:0] stage;
  logic       ack;

  alu_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .A        (A),
    .B        (B),
    .op       (op),
    .valid    (valid),
    .stage    (stage),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per edge; the synchronized level seen at edge k is the raw
  // sample from edge k-2. A level is accepted once the last D synchronized
  // samples all differ from the accepted level; the action lands one edge later.
  bit q_e[$];
  bit q_c[$];
  bit acc_e, acc_c, pend_e, pend_c;
  int m_A, m_B, m_op, m_state;
  bit m_ack;
  bit m_live = 1'b0;

  function automatic bit all_differ(input bit q[$], input bit acc);
    for (int i = 0; i < D; i++) begin
      if (q[q.size() - 2 - i] == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q_e.delete();
      q_c.delete();
      for (int i = 0; i < D + 2; i++) begin
        q_e.push_back(1'b0);
        q_c.push_back(1'b0);
      end
      acc_e = 0; acc_c = 0; pend_e = 0; pend_c = 0;
      m_A = 0; m_B = 0; m_op = 0; m_state = 0; m_ack = 0;
      m_live = 1'b1;
    end else begin
      m_ack = pend_c || pend_e;
      if (pend_c) begin
        m_A = 0; m_B = 0; m_op = 0; m_state = 0;
      end else if (pend_e) begin
        case (m_state)
          0: begin m_A = sw; m_state = 1; end
          1: begin m_B = sw; m_state = 2; end
          2: begin m_op = sw % 8; m_state = 3; end
          default: begin m_A = sw; m_state = 1; end
        endcase
      end
      pend_e = 0;
      pend_c = 0;
      if (all_differ(q_e, acc_e)) begin acc_e = !acc_e; pend_e = acc_e; end
      if (all_differ(q_c, acc_c)) begin acc_c = !acc_c; pend_c = acc_c; end
      q_e.push_back(btn_enter); void'(q_e.pop_front());
      q_c.push_back(btn_clear); void'(q_c.pop_front());
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_A", A, m_A);
      check("cmp_B", B, m_B);
      check("cmp_op", op, m_op);
      check("cmp_stage", stage, m_state);
      check("cmp_valid", valid, (m_state == 3) ? 1 : 0);
      check("cmp_ack", ack, m_ack);
      if (ack) ack_count++;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input bit en, input bit cl, input int n);
    btn_enter = en;
    btn_clear = cl;
    repeat (n) @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic enter_val(input logic [3:0] v);
    sw = v;
    hold(1'b1, 1'b0, 10);
    idle(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int a0;
  int s_A, s_B, s_op, s_st;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_op", op, 0);
    check("rst_valid", valid, 0);
    check("rst_stage", stage, 0);
    check("rst_ack", ack, 0);
    rst_n = 1'b1;
    idle(2);

    // Glitch of two cycles is ignored.
    sw = 4'h9;
    hold(1'b1, 1'b0, 2);
    idle(15);
    check("glitch_A", A, 0);
    check("glitch_stage", stage, 0);
    check("glitch_ack", ack_count, 0);

    // Eight-cycle press: capture exactly on the 7th edge.
    sw = 4'h7;
    btn_enter = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 6) check("lat_before", A, 0);
      if (e == 7) check("lat_at", A, 7);
    end
    @(negedge clk);
    btn_enter = 1'b0;
    idle(12);
    check("lat_stage", stage, 1);
    check("lat_single_ack", ack_count, 1);

    // Full sequence from a fresh reset.
    do_reset();
    idle(2);
    a0 = ack_count;
    enter_val(4'h5);
    enter_val(4'h3);
    enter_val(4'h1);
    check("seq_A", A, 5);
    check("seq_B", B, 3);
    check("seq_op", op, 1);
    check("seq_valid", valid, 1);
    check("seq_stage", stage, 3);
    check("seq_acks", ack_count - a0, 3);
    check("model_seq_A", m_A, 5);
    check("model_seq_op", m_op, 1);

    // Re-entry from READY.
    enter_val(4'hA);
    check("reent_A", A, 10);
    check("reent_B", B, 3);
    check("reent_op", op, 1);
    check("reent_stage", stage, 1);
    check("reent_valid", valid, 0);

    // Clear wins over a simultaneous enter in ENTER_OP.
    enter_val(4'h3);
    check("pre_clr_stage", stage, 2);
    a0 = ack_count;
    hold(1'b1, 1'b1, 10);
    idle(12);
    check("clr_A", A, 0);
    check("clr_B", B, 0);
    check("clr_op", op, 0);
    check("clr_stage", stage, 0);
    check("clr_valid", valid, 0);
    check("clr_acks", ack_count - a0, 1);
    check("model_clr_stage", m_state, 0);

    // Reset in the middle of a debounce.
    enter_val(4'h6);
    check("pre_rst_A", A, 6);
    a0 = ack_count;
    btn_enter = 1'b1;
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    btn_enter = 1'b0;
    idle(15);
    check("mid_rst_A", A, 0);
    check("mid_rst_stage", stage, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_acks", ack_count - a0, 0);

    // Switch activity alone changes nothing, in every state.
    for (int st = 0; st < 4; st++) begin
      s_A = m_A; s_B = m_B; s_op = m_op; s_st = m_state;
      for (int c = 0; c < 50; c++) begin
        sw = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      check("iso_A", A, s_A);
      check("iso_B", B, s_B);
      check("iso_op", op, s_op);
      check("iso_stage", stage, s_st);
      check("iso_stage_idx", stage, st);
      enter_val(4'($urandom_range(0, 15)));
    end

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      sw = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: hold(1'b1, 1'b0, $urandom_range(1, 12));
        4, 5:       hold(1'b0, 1'b1, $urandom_range(1, 12));
        6:          hold(1'b1, 1'b1, $urandom_range(1, 12));
        7:          begin
                      btn_enter = 1'($urandom_range(0, 1));
                      do_reset();
                      btn_enter = 1'b0;
                    end
        default:    begin
                      btn_enter = 1'b1;
                      idle($urandom_range(1, 6));
                      sw = 4'($urandom_range(0, 15));
                      idle($urandom_range(1, 6));
                      btn_enter = 1'b0;
                    end
      endcase
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
      idle($urandom_range(0, 10));
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
